uart_core: RTL and testbench
============================

// Module: uart_core
// PURPOSE
//  Full-duplex UART with configurable frame format (data bits, parity, stop bits) and divider.
//  Replaces the fixed 8N1, receive-only UART: adds transmitter, parity, 2-stop-bit mode, overrun/framing flags.
//  Sits between the host serial pins and the bootloader command parser; break detection is kept for resync.
// PARAMETERS
//  CLK_DIV    16  clocks per bit period, >=4; mid-bit sample at CLK_DIV/2 after start edge
//  DATA_BITS  8   data bits per frame, 5..8, LSB first
//  PARITY     0   0=none, 1=odd, 2=even
//  STOP_BITS  1   1 or 2
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          reset, asynchronous, active-low
//  rx             in   1          serial input, async to clk
//  tx             out  1          serial output, idle high
//  tx_valid       in   1          host offers tx_data
//  tx_data        in   DATA_BITS  byte to send
//  tx_ready       out  1          transmitter can accept
//  rx_valid       out  1          rx_data holds unread byte
//  rx_data        out  DATA_BITS  received byte
//  rx_ready       in   1          host consumes rx_data
//  rx_parity_err  out  1          parity flag for current rx_data, qualified by rx_valid
//  rx_frame_err   out  1          1-cycle pulse: stop bit low, data non-zero
//  rx_overrun     out  1          1-cycle pulse: byte completed while rx_valid && !rx_ready; new byte dropped
//  rx_break       out  1          1-cycle pulse when line returns high after a break
// BEHAVIOUR
//  Reset: tx=1, tx_ready=1, rx_valid=0, rx_data=0, all flags/pulses 0, both FSMs IDLE; applies mid-frame immediately.
//  rx passes through a 2-FF synchroniser (reset to 1); all RX decisions use the synchronised signal.
//  RX FSM: IDLE->START on sync rx==0, counter preset so first sample lands at CLK_DIV/2.
//   START: sample 0 -> DATA; sample 1 -> IDLE (glitch, no output).
//   DATA: shift DATA_BITS samples LSB first, one per CLK_DIV; -> PARITY if PARITY!=0 else STOP.
//   PARITY: sample parity bit, compute error vs odd/even of data.
//   STOP: sample 1 -> IDLE and deliver byte; sample 0 with data==0 and parity bit==0 -> BREAK;
//     sample 0 otherwise -> ERROR, pulse rx_frame_err, byte discarded.
//   Only first stop bit is checked on RX; STOP_BITS affects TX only.
//   BREAK/ERROR: wait for sync rx==1 -> IDLE; BREAK exit pulses rx_break, no rx_valid.
//  Delivery: cycle after STOP->IDLE, rx_valid=1, rx_data/rx_parity_err loaded, unless rx_valid&&!rx_ready then.
//   rx_valid held until rx_valid&&rx_ready clears it; same-cycle clear+deliver: new byte wins, rx_valid stays 1.
//  TX FSM: IDLE(tx_ready=1) accepts on tx_valid&&tx_ready; tx_ready=0 next cycle.
//   START(0) -> DATA_BITS data LSB first -> optional parity -> STOP_BITS stop(1), each CLK_DIV clocks.
//   tx_ready returns 1 the cycle after the last stop period ends; back-to-back frames have no idle gap.
//   tx_data captured at accept; later changes ignored.
//  Counters wrap at CLK_DIV-1; width $clog2(CLK_DIV)+1.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each RX sample is 2-of-3 majority of sync rx at CLK_DIV/2-1, /2, /2+1;
//   START glitch test and break test use the voted value. Requires CLK_DIV>=6.
//  Undefined: single sample at CLK_DIV/2. Frame timing and latency identical either way.
// STRUCTURE
//  uart_pkg: RX/TX state encodings, PARITY_NONE/ODD/EVEN constants, parity function.
//  Sub-module uart_tx (TX FSM + shifter + divider); RX, synchroniser and host interface stay in uart_core.
// TESTING
//  CLK_DIV=16, 8N1: drive 0xA5 on rx -> rx_valid with rx_data=0xA5, parity_err=0; hold until rx_ready.
//  Loopback tx->rx, 8E2: send 0x00,0xFF,0x3C back-to-back -> same 3 bytes, tx_ready low 12*16 clk each.
//  8O1, 0x03 with even-parity bit -> rx_valid, rx_data=0x03, rx_parity_err=1.
//  rx low 12 bit times then high -> one rx_break pulse after release; no rx_valid, no rx_frame_err.
//  rx low 4 clocks -> no output; 0x55 with low stop bit -> rx_frame_err pulse; two bytes, rx_ready=0 -> rx_overrun, rx_data=first.
//  rst_n low mid-TX frame -> tx=1, tx_ready=1 asynchronously; next frame after release correct.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, parity modes and parity helper
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK,
    RX_ERROR
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Parity bit that goes on the wire for the given data (zero-extended to 8 bits).
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    case (mode)
      PARITY_ODD:  return ~^data;
      PARITY_EVEN: return ^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: frame FSM, bit divider and data shifter
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  tx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par;
  logic                 done;
  logic                 tx_d;

  assign done     = (cnt == CNT_MAX);
  assign tx_ready = (state_q == TX_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  // Next state, and the line level for the coming cycle so tx can be registered.
  always_comb begin
    state_d = state_q;
    tx_d    = 1'b1;
    case (state_q)
      TX_IDLE:   if (tx_valid) state_d = TX_START;
      TX_START:  if (done) state_d = TX_DATA;
      TX_DATA:   if (done && bit_cnt == 4'(DATA_BITS - 1))
                   state_d = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (done) state_d = TX_STOP;
      TX_STOP:   if (done && bit_cnt == 4'(STOP_BITS - 1)) state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = (state_q == TX_DATA && done) ? shift[1] : shift[0];
      TX_PARITY: tx_d = par;
      default:   tx_d = 1'b1;
    endcase
  end

  // Divider, bit counter, shifter and registered line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
    end else begin
      tx <= tx_d;
      if (state_q == TX_IDLE) begin
        cnt     <= '0;
        bit_cnt <= '0;
        if (tx_valid) begin
          shift <= tx_data;
          par   <= parity_bit(8'(tx_data), PARITY);
        end
      end else begin
        cnt <= done ? '0 : cnt + CW'(1);
        if (done) begin
          bit_cnt <= (state_d != state_q) ? 4'd0 : bit_cnt + 4'd1;
          if (state_q == TX_DATA) shift <= shift >> 1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART top (RX, synchroniser, host side); UART_RX_MAJORITY_EN selects 2-of-3 RX voting
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_break
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  // Decision point is one clock after the nominal mid-bit sample so the
  // +1 neighbour is available for voting; non-voting builds use the delayed copy.
  localparam logic [CW-1:0] CNT_PRESET = CW'(CLK_DIV / 2 - 1);

  logic rx_meta, rx_sync, rx_d1, rx_bit;

`ifdef UART_RX_MAJORITY_EN
  logic rx_d2;

  // Synchroniser plus two-deep history for the 3-sample vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_d1   <= 1'b1;
      rx_d2   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_d1   <= rx_sync;
      rx_d2   <= rx_d1;
    end
  end

  assign rx_bit = (rx_d2 & rx_d1) | (rx_d2 & rx_sync) | (rx_d1 & rx_sync);
`else
  // Synchroniser plus one-cycle history holding the mid-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_d1   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_d1   <= rx_sync;
    end
  end

  assign rx_bit = rx_d1;
`endif

  rx_state_t            rx_q, rx_n;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_bits;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par;
  logic                 sample;
  logic                 deliver, deliver_q;
  logic                 frame_err_n, break_n;

  assign sample = (rx_cnt == CNT_MAX);

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_q <= RX_IDLE;
    else        rx_q <= rx_n;
  end

  // RX next state and event strobes.
  always_comb begin
    rx_n        = rx_q;
    deliver     = 1'b0;
    frame_err_n = 1'b0;
    break_n     = 1'b0;
    case (rx_q)
      RX_IDLE:   if (!rx_sync) rx_n = RX_START;
      RX_START:  if (sample) rx_n = rx_bit ? RX_IDLE : RX_DATA;
      RX_DATA:   if (sample && rx_bits == 4'(DATA_BITS - 1))
                   rx_n = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (sample) rx_n = RX_STOP;
      RX_STOP: begin
        if (sample) begin
          if (rx_bit) begin
            rx_n    = RX_IDLE;
            deliver = 1'b1;
          end else if (rx_shift == '0 && !rx_par) begin
            rx_n = RX_BREAK;
          end else begin
            rx_n        = RX_ERROR;
            frame_err_n = 1'b1;
          end
        end
      end
      RX_BREAK: begin
        if (rx_sync) begin
          rx_n    = RX_IDLE;
          break_n = 1'b1;
        end
      end
      RX_ERROR:  if (rx_sync) rx_n = RX_IDLE;
      default:   rx_n = RX_IDLE;
    endcase
  end

  // RX divider, bit counter, data shifter and parity capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      if (rx_q == RX_IDLE) begin
        rx_cnt  <= CNT_PRESET;
        rx_bits <= '0;
      end else begin
        rx_cnt <= sample ? '0 : rx_cnt + CW'(1);
      end
      if (rx_q == RX_START) rx_par <= 1'b0;
      if (sample && rx_q == RX_DATA) begin
        rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
        rx_bits  <= rx_bits + 4'd1;
      end
      if (sample && rx_q == RX_PARITY) rx_par <= rx_bit;
    end
  end

  // Host side: hold a byte until consumed; a fresh byte wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deliver_q     <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      deliver_q    <= deliver;
      rx_frame_err <= frame_err_n;
      rx_break     <= break_n;
      rx_overrun   <= 1'b0;
      if (deliver_q && rx_valid && !rx_ready) begin
        rx_overrun <= 1'b1;
      end else if (deliver_q) begin
        rx_valid      <= 1'b1;
        rx_data       <= rx_shift;
        rx_parity_err <= (PARITY != PARITY_NONE) &&
                         (rx_par != parity_bit(8'(rx_shift), PARITY));
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  uart_tx #(
    .CLK_DIV  (CLK_DIV),
    .DATA_BITS(DATA_BITS),
    .PARITY   (PARITY),
    .STOP_BITS(STOP_BITS)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx)
  );

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - directed self-checking bench for uart_core (8N1, 8E2 loopback, 8O1)
module tb_uart_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  int checks = 0;
  int failures = 0;

  // Instance A: 8N1, bench drives rx
  logic       rx_a = 1'b1, tx_a, tx_valid_a = 1'b0, tx_ready_a;
  logic [7:0] tx_data_a = 8'h00, rx_data_a;
  logic       rx_valid_a, rx_ready_a = 1'b0;
  logic       perr_a, fe_a, ov_a, brk_a;
  // Instance B: 8E2, tx looped back to rx
  logic       tx_b, tx_valid_b = 1'b0, tx_ready_b;
  logic [7:0] tx_data_b = 8'h00, rx_data_b;
  logic       rx_valid_b, rx_ready_b = 1'b1;
  logic       perr_b, fe_b, ov_b, brk_b;
  // Instance C: 8O1, bench drives rx
  logic       rx_c = 1'b1, tx_c, tx_valid_c = 1'b0, tx_ready_c;
  logic [7:0] tx_data_c = 8'h00, rx_data_c;
  logic       rx_valid_c, rx_ready_c = 1'b0;
  logic       perr_c, fe_c, ov_c, brk_c;

  uart_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .tx(tx_a), .tx_valid(tx_valid_a),
    .tx_data(tx_data_a), .tx_ready(tx_ready_a), .rx_valid(rx_valid_a),
    .rx_data(rx_data_a), .rx_ready(rx_ready_a), .rx_parity_err(perr_a),
    .rx_frame_err(fe_a), .rx_overrun(ov_a), .rx_break(brk_a));

  uart_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(tx_b), .tx(tx_b), .tx_valid(tx_valid_b),
    .tx_data(tx_data_b), .tx_ready(tx_ready_b), .rx_valid(rx_valid_b),
    .rx_data(rx_data_b), .rx_ready(rx_ready_b), .rx_parity_err(perr_b),
    .rx_frame_err(fe_b), .rx_overrun(ov_b), .rx_break(brk_b));

  uart_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_c), .tx(tx_c), .tx_valid(tx_valid_c),
    .tx_data(tx_data_c), .tx_ready(tx_ready_c), .rx_valid(rx_valid_c),
    .rx_data(rx_data_c), .rx_ready(rx_ready_c), .rx_parity_err(perr_c),
    .rx_frame_err(fe_c), .rx_overrun(ov_c), .rx_break(brk_c));

  // Pulse counters and loopback capture, sampled away from the active edge.
  int n_fe_a = 0, n_ov_a = 0, n_brk_a = 0, n_err_b = 0, n_err_c = 0;
  logic [7:0] got_b [$];
  always @(negedge clk) begin
    if (fe_a)  n_fe_a++;
    if (ov_a)  n_ov_a++;
    if (brk_a) n_brk_a++;
    if (fe_b || ov_b || brk_b || (rx_valid_b && perr_b)) n_err_b++;
    if (fe_c || ov_c || brk_c) n_err_c++;
    if (rx_valid_b) got_b.push_back(rx_data_b);
  end

  // Drive n bits LSB first, 16 clocks each, on instance A (sel=0) or C (sel=1).
  task automatic drive_bits(input int sel, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx_a = bits[i];
      else          rx_c = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    if (tx_a !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx_a); end
    checks++;
    if (tx_ready_a !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready_a); end
    checks++;
    if (rx_valid_a !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid_a); end
    checks++;
    if (rx_data_a !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data_a); end
    checks++;
    if ({perr_a, fe_a, ov_a, brk_a} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {perr_a, fe_a, ov_a, brk_a});
    end
    checks++;
  endtask

  task automatic test_rx_8n1();
    drive_bits(0, {3'b111, 8'hA5, 1'b0}, 10);
    if (rx_valid_a !== 1'b1) begin failures++; $display("FAIL rx8n1_valid got=%b exp=1", rx_valid_a); end
    checks++;
    if (rx_data_a !== 8'hA5) begin failures++; $display("FAIL rx8n1_data got=%h exp=a5", rx_data_a); end
    checks++;
    if (perr_a !== 1'b0) begin failures++; $display("FAIL rx8n1_perr got=%b exp=0", perr_a); end
    checks++;
    repeat (40) @(negedge clk);
    if (rx_valid_a !== 1'b1 || rx_data_a !== 8'hA5) begin
      failures++; $display("FAIL rx8n1_hold got=%b/%h exp=1/a5", rx_valid_a, rx_data_a);
    end
    checks++;
    rx_ready_a = 1'b1;
    @(negedge clk);
    rx_ready_a = 1'b0;
    if (rx_valid_a !== 1'b0) begin failures++; $display("FAIL rx8n1_consume got=%b exp=0", rx_valid_a); end
    checks++;
  endtask

  task automatic test_parity_8o1();
    int t;
    // 0x03 has even popcount: odd parity needs 1, so a 0 parity bit is an error
    drive_bits(1, {2'b11, 1'b0, 8'h03, 1'b0}, 11);
    t = 0;
    while (rx_valid_c !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (rx_valid_c !== 1'b1) begin failures++; $display("FAIL par_bad_valid got=%b exp=1", rx_valid_c); end
    checks++;
    if (rx_data_c !== 8'h03) begin failures++; $display("FAIL par_bad_data got=%h exp=03", rx_data_c); end
    checks++;
    if (perr_c !== 1'b1) begin failures++; $display("FAIL par_bad_perr got=%b exp=1", perr_c); end
    checks++;
    rx_ready_c = 1'b1; @(negedge clk); rx_ready_c = 1'b0;
    drive_bits(1, {2'b11, 1'b1, 8'h03, 1'b0}, 11);
    t = 0;
    while (rx_valid_c !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (rx_valid_c !== 1'b1 || rx_data_c !== 8'h03 || perr_c !== 1'b0) begin
      failures++; $display("FAIL par_good got=%b/%h/%b exp=1/03/0", rx_valid_c, rx_data_c, perr_c);
    end
    checks++;
    if (n_err_c !== 0) begin failures++; $display("FAIL par_c_events got=%0d exp=0", n_err_c); end
    checks++;
    rx_ready_c = 1'b1; @(negedge clk); rx_ready_c = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] lb [0:2];
    int lowcnt;
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h3C;
    got_b.delete();
    tx_valid_b = 1'b1;
    tx_data_b  = lb[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lowcnt = 0;
      while (tx_ready_b === 1'b0 && lowcnt < 400) begin lowcnt++; @(negedge clk); end
      if (lowcnt !== 192) begin failures++; $display("FAIL lb_ready_low[%0d] got=%0d exp=192", i, lowcnt); end
      checks++;
      if (i < 2) tx_data_b = lb[i+1];
      else       tx_valid_b = 1'b0;
    end
    repeat (40) @(negedge clk);
    if (got_b.size() !== 3) begin
      failures++; $display("FAIL lb_count got=%0d exp=3", got_b.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (got_b[i] !== lb[i]) begin failures++; $display("FAIL lb_data[%0d] got=%h exp=%h", i, got_b[i], lb[i]); end
        checks++;
      end
    end
    checks++;
    if (n_err_b !== 0) begin failures++; $display("FAIL lb_events got=%0d exp=0", n_err_b); end
    checks++;
  endtask

  task automatic test_break();
    int b0, f0;
    b0 = n_brk_a; f0 = n_fe_a;
    rx_a = 1'b0;
    repeat (12 * 16) @(negedge clk);
    if (n_brk_a !== b0) begin failures++; $display("FAIL brk_early got=%0d exp=%0d", n_brk_a, b0); end
    checks++;
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    if (n_brk_a !== b0 + 1) begin failures++; $display("FAIL brk_pulse got=%0d exp=%0d", n_brk_a, b0 + 1); end
    checks++;
    if (n_fe_a !== f0 || rx_valid_a !== 1'b0) begin
      failures++; $display("FAIL brk_side got=fe%0d/v%b exp=fe%0d/v0", n_fe_a, rx_valid_a, f0);
    end
    checks++;
  endtask

  task automatic test_glitch();
    int b0, f0;
    b0 = n_brk_a; f0 = n_fe_a;
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    if (rx_valid_a !== 1'b0 || n_fe_a !== f0 || n_brk_a !== b0) begin
      failures++; $display("FAIL glitch got=v%b/fe%0d/brk%0d exp=v0/fe%0d/brk%0d", rx_valid_a, n_fe_a, n_brk_a, f0, b0);
    end
    checks++;
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = n_fe_a;
    drive_bits(0, {3'b110, 8'h55, 1'b0}, 10);
    rx_a = 1'b1;
    repeat (32) @(negedge clk);
    if (n_fe_a !== f0 + 1) begin failures++; $display("FAIL frame_err got=%0d exp=%0d", n_fe_a, f0 + 1); end
    checks++;
    if (rx_valid_a !== 1'b0) begin failures++; $display("FAIL frame_err_valid got=%b exp=0", rx_valid_a); end
    checks++;
  endtask

  task automatic test_overrun();
    int o0;
    o0 = n_ov_a;
    drive_bits(0, {3'b111, 8'h11, 1'b0}, 10);
    drive_bits(0, {3'b111, 8'h22, 1'b0}, 10);
    repeat (16) @(negedge clk);
    if (n_ov_a !== o0 + 1) begin failures++; $display("FAIL overrun got=%0d exp=%0d", n_ov_a, o0 + 1); end
    checks++;
    if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h11) begin
      failures++; $display("FAIL overrun_keep got=%b/%h exp=1/11", rx_valid_a, rx_data_a);
    end
    checks++;
    rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    int t;
    logic [7:0] dec;
    tx_valid_a = 1'b1; tx_data_a = 8'h5A;
    @(negedge clk);
    tx_valid_a = 1'b0;
    repeat (50) @(negedge clk);
    // 3rd bit period after start: data bit 2 of 0x5A is 0
    if (tx_a !== 1'b0 || tx_ready_a !== 1'b0) begin
      failures++; $display("FAIL midtx_busy got=%b/%b exp=0/0", tx_a, tx_ready_a);
    end
    checks++;
    #2 rst_n = 1'b0;
    #1;
    if (tx_a !== 1'b1 || tx_ready_a !== 1'b1) begin
      failures++; $display("FAIL async_reset got=%b/%b exp=1/1", tx_a, tx_ready_a);
    end
    checks++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tx_valid_a = 1'b1; tx_data_a = 8'hC3;
    @(negedge clk);
    tx_valid_a = 1'b0;
    t = 0;
    while (tx_a !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    repeat (7) @(negedge clk);
    if (tx_a !== 1'b0) begin failures++; $display("FAIL post_start got=%b exp=0", tx_a); end
    checks++;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      dec[i] = tx_a;
    end
    repeat (16) @(negedge clk);
    if (dec !== 8'hC3) begin failures++; $display("FAIL post_data got=%h exp=c3", dec); end
    checks++;
    if (tx_a !== 1'b1) begin failures++; $display("FAIL post_stop got=%b exp=1", tx_a); end
    checks++;
    t = 0;
    while (tx_ready_a !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    if (tx_ready_a !== 1'b1) begin failures++; $display("FAIL post_ready got=%b exp=1", tx_ready_a); end
    checks++;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_rx_8n1();
    test_parity_8o1();
    test_back_to_back();
    test_break();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
